regfile_fwd: RTL and testbench
==============================

# regfile_fwd

General-purpose register file for the five-stage integer pipeline, with operand forwarding. Holds the 32 architectural registers. Takes its write port from the WB stage. Supplies the two source operands consumed by the ID/EX path, which carries them as `reg1`/`reg2` into the ALU. Resolves read-after-write hazards without stalling: the results the EX, MEM and WB stages are still carrying (`wdata`/`wd`/`wreg` triples) are muxed onto each read port.

## Interface
Parameters:
- `DATA_W`, 32, register and operand width
- `ADDR_W`, 5, register address width
- `NREGS`, 32, number of registers; must equal 2**`ADDR_W`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `we`  in  1  WB write enable
- `waddr`  in  `ADDR_W`  WB destination register
- `wdata`  in  `DATA_W`  WB write data
- `ex_wreg`  in  1  EX stage will write a register
- `ex_wd`  in  `ADDR_W`  EX destination
- `ex_wdata`  in  `DATA_W`  EX result
- `mem_wreg`  in  1  MEM stage will write a register
- `mem_wd`  in  `ADDR_W`  MEM destination
- `mem_wdata`  in  `DATA_W`  MEM result
- `re1`  in  1  read-port-1 enable
- `raddr1`  in  `ADDR_W`  read-port-1 address
- `rdata1`  out  `DATA_W`  read-port-1 operand
- `re2`  in  1  read-port-2 enable
- `raddr2`  in  `ADDR_W`  read-port-2 address
- `rdata2`  out  `DATA_W`  read-port-2 operand
- `fwd1`  out  2  port-1 source: 0 = array/none, 1 = WB, 2 = MEM, 3 = EX
- `fwd2`  out  2  port-2 source, same encoding as `fwd1`

## Operation
- **Storage:** `NREGS` x `DATA_W` flops.
  - `rst` low clears every entry to 0 asynchronously.
  - All outputs are combinational. While `rst` is low, `rdata1`/`rdata2` = 0 and `fwd1`/`fwd2` = 0 regardless of inputs.
- **Write:** on a rising `clk` with `rst` high, `we` = 1 and `waddr` != 0, entry `waddr` <= `wdata`.
  - Writes to register 0 are discarded; entry 0 stays 0 permanently.
- **Read (per port, evaluated in priority order):**
  1. `reN` = 0, or `raddrN` = 0 -> `rdataN` = 0, `fwdN` = 0.
  2. `ex_wreg` = 1 and `ex_wd` = `raddrN` -> `ex_wdata`, `fwdN` = 3.
  3. `mem_wreg` = 1 and `mem_wd` = `raddrN` -> `mem_wdata`, `fwdN` = 2.
  4. `we` = 1 and `waddr` = `raddrN` -> `wdata`, `fwdN` = 1.
  5. Otherwise -> array entry `raddrN`, `fwdN` = 0.
- **Priority rationale:** the youngest producer wins. If EX, MEM and WB all target the same register, the EX value is returned.
- **Port independence:** the two ports are independent. Both may read the same address, and both may be forwarded from the same stage in the same cycle.
- **Forward-source validity:** a stage with `wreg` = 0 never forwards, whatever its `wd`/`wdata` values.
- **Widths:** no arithmetic is performed. Address compares are full `ADDR_W` equality.

## Timing
- Read latency: 0 cycles; a purely combinational path from address and forward inputs to `rdataN`/`fwdN`.
- Write latency: 1 cycle into the array. The WB bypass makes the value visible in the same cycle it is presented.
- Reset mid-operation:
  - Asserting `rst` clears the array immediately; no clock is needed.
  - A write presented on the edge where `rst` deasserts is not performed if `rst` is still low at that edge.
  - After release, reads return 0 until written.
- Simultaneous write and read of the same nonzero address: returns new `wdata` via the bypass. The array updates at the edge.
- No stall or handshake. The block is always ready, and callers may change addresses every cycle.

## Structure
- Shared package or `define` file holds:
  - `ZeroWord`
  - the reset-active level
  - bus widths (`RegisterBus`, `RegisterAddressBus`)
  - the `fwd` encoding constants: `FWD_NONE`, `FWD_WB`, `FWD_MEM`, `FWD_EX`
- One sub-module, `fwd_sel`:
  - inputs: one read address/enable, the three producer triples, and the array word
  - outputs: operand and `fwd` code
  - instantiated twice, once per read port
- The top level holds only the array, the write logic and the two `fwd_sel` instances.

## Test plan
- **Reset:** drive `rst` low mid-run after writing `r5` = 0x1234_5678, then release. Read `r5` -> `rdata1` = 0, `fwd1` = 0.
- **Register 0:** `we` = 1, `waddr` = 0, `wdata` = 0xFFFF_FFFF. Next cycle read `r0` on both ports -> 0. Also set `ex_wreg` = 1, `ex_wd` = 0, `ex_wdata` = 0xAAAA_AAAA -> still 0, `fwd` = 0.
- **Write then read:** write `r7` = 0xDEAD_BEEF. Same cycle read `r7` -> 0xDEAD_BEEF, `fwd1` = 1. Next cycle, with `we` = 0 -> 0xDEAD_BEEF, `fwd1` = 0.
- **Three-way hazard:** EX/MEM/WB all target `r3` with 0x3, 0x2, 0x1 -> `rdata1` = 0x3, `fwd1` = 3. Drop `ex_wreg` -> 0x2, `fwd` = 2. Drop `mem_wreg` -> 0x1, `fwd` = 1.
- **Port independence:** port 1 reads `r4`, port 2 reads `r9`. EX targets `r9` = 0x0000_0099 and the array holds `r4` = 0x44 -> `rdata1` = 0x44, `fwd1` = 0; `rdata2` = 0x99, `fwd2` = 3.
- **Disabled port:** `re2` = 0 while reading a written `r12` that is also an EX target -> `rdata2` = 0, `fwd2` = 0.

Source files
------------

// File: rtl/regfile_fwd_pkg.sv
// Shared widths, reset level and forwarding-source codes for the
// register file and its operand forwarding selectors.
package regfile_fwd_pkg;

  localparam int RegisterBus        = 32;
  localparam int RegisterAddressBus = 5;

  localparam logic [RegisterBus-1:0] ZeroWord = '0;

  // Reset is asserted when rst sits at this level.
  localparam logic RstEnable = 1'b0;

  // Source of a read-port operand; higher code = younger producer.
  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_WB   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_EX   = 2'd3
  } fwd_e;

endpackage

// File: rtl/regfile_fwd_if.sv
// Bundle of the WB write port, the EX/MEM producer triples and the two
// read ports. The pipeline drives through master, the register file
// consumes through slave.
interface regfile_fwd_if
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W = RegisterBus,
  parameter int ADDR_W = RegisterAddressBus
) ();

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  logic              ex_wreg;
  logic [ADDR_W-1:0] ex_wd;
  logic [DATA_W-1:0] ex_wdata;

  logic              mem_wreg;
  logic [ADDR_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_wdata;

  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic [1:0]        fwd1;

  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [1:0]        fwd2;

  modport master (
    output we, waddr, wdata,
    output ex_wreg, ex_wd, ex_wdata,
    output mem_wreg, mem_wd, mem_wdata,
    output re1, raddr1, re2, raddr2,
    input  rdata1, fwd1, rdata2, fwd2
  );

  modport slave (
    input  we, waddr, wdata,
    input  ex_wreg, ex_wd, ex_wdata,
    input  mem_wreg, mem_wd, mem_wdata,
    input  re1, raddr1, re2, raddr2,
    output rdata1, fwd1, rdata2, fwd2
  );

endinterface

// File: rtl/regfile_fwd_fwd_sel.sv
// Per-read-port operand selector: picks the youngest in-flight producer
// of the requested register, falling back to the stored array word.
module fwd_sel
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W = RegisterBus,
  parameter int ADDR_W = RegisterAddressBus
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ex_wreg,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] array_word,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        fwd
);

  // Priority mux: reset/disabled/r0, then EX, MEM, WB, then the array.
  always_comb begin
    rdata = '0;
    fwd   = FWD_NONE;
    if (rst == RstEnable || !re || raddr == '0) begin
      rdata = '0;
      fwd   = FWD_NONE;
    end else if (ex_wreg && ex_wd == raddr) begin
      rdata = ex_wdata;
      fwd   = FWD_EX;
    end else if (mem_wreg && mem_wd == raddr) begin
      rdata = mem_wdata;
      fwd   = FWD_MEM;
    end else if (we && waddr == raddr) begin
      rdata = wdata;
      fwd   = FWD_WB;
    end else begin
      rdata = array_word;
      fwd   = FWD_NONE;
    end
  end

endmodule

// File: rtl/regfile_fwd.sv
// 32-entry general-purpose register file with EX/MEM/WB operand
// forwarding on both read ports. Register 0 reads as zero always.
module regfile_fwd
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W = RegisterBus,
  parameter int ADDR_W = RegisterAddressBus,
  parameter int NREGS  = 2 ** ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  regfile_fwd_if.slave bus
);

  logic [DATA_W-1:0] regs [NREGS];

  // Array write from WB; r0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.we && bus.waddr != '0) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  fwd_sel #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sel1 (
    .rst        (rst),
    .re         (bus.re1),
    .raddr      (bus.raddr1),
    .ex_wreg    (bus.ex_wreg),
    .ex_wd      (bus.ex_wd),
    .ex_wdata   (bus.ex_wdata),
    .mem_wreg   (bus.mem_wreg),
    .mem_wd     (bus.mem_wd),
    .mem_wdata  (bus.mem_wdata),
    .we         (bus.we),
    .waddr      (bus.waddr),
    .wdata      (bus.wdata),
    .array_word (regs[bus.raddr1]),
    .rdata      (bus.rdata1),
    .fwd        (bus.fwd1)
  );

  fwd_sel #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sel2 (
    .rst        (rst),
    .re         (bus.re2),
    .raddr      (bus.raddr2),
    .ex_wreg    (bus.ex_wreg),
    .ex_wd      (bus.ex_wd),
    .ex_wdata   (bus.ex_wdata),
    .mem_wreg   (bus.mem_wreg),
    .mem_wd     (bus.mem_wd),
    .mem_wdata  (bus.mem_wdata),
    .we         (bus.we),
    .waddr      (bus.waddr),
    .wdata      (bus.wdata),
    .array_word (regs[bus.raddr2]),
    .rdata      (bus.rdata2),
    .fwd        (bus.fwd2)
  );

endmodule

// File: tb/tb_regfile_fwd.sv
// Directed and randomized bench for regfile_fwd against a behavioural
// register-file-with-bypass model.
module tb_regfile_fwd;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  logic [31:0] model [32];

  regfile_fwd_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_fwd #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_p1(input string tag, input logic [31:0] d, input logic [1:0] f);
    cmp({tag, "_rdata1"}, bus.rdata1, d);
    cmp({tag, "_fwd1"}, 32'(bus.fwd1), 32'(f));
  endtask

  task automatic expect_p2(input string tag, input logic [31:0] d, input logic [1:0] f);
    cmp({tag, "_rdata2"}, bus.rdata2, d);
    cmp({tag, "_fwd2"}, 32'(bus.fwd2), 32'(f));
  endtask

  // Reference read: scan producers youngest-first, else the model array.
  function automatic void ref_read(input logic re, input logic [4:0] ra,
                                   output logic [31:0] d, output logic [1:0] f);
    logic        v [3];
    logic [4:0]  a [3];
    logic [31:0] w [3];
    v[0] = bus.ex_wreg;  a[0] = bus.ex_wd;  w[0] = bus.ex_wdata;
    v[1] = bus.mem_wreg; a[1] = bus.mem_wd; w[1] = bus.mem_wdata;
    v[2] = bus.we;       a[2] = bus.waddr;  w[2] = bus.wdata;
    d = 32'h0;
    f = 2'd0;
    if (!rst || !re || ra == 5'd0) return;
    for (int i = 0; i < 3; i++) begin
      if (v[i] && a[i] == ra) begin
        d = w[i];
        f = 2'(3 - i);
        return;
      end
    end
    d = model[ra];
  endfunction

  task automatic check_model(input string tag);
    logic [31:0] d;
    logic [1:0]  f;
    ref_read(bus.re1, bus.raddr1, d, f);
    expect_p1(tag, d, f);
    ref_read(bus.re2, bus.raddr2, d, f);
    expect_p2(tag, d, f);
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (!v) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end
  endtask

  task automatic tick();
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    w = rst && bus.we && bus.waddr != 5'd0;
    a = bus.waddr;
    d = bus.wdata;
    @(posedge clk);
    if (w) model[a] = d;
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0;       bus.waddr = '0;  bus.wdata = '0;
    bus.ex_wreg = 1'b0;  bus.ex_wd = '0;  bus.ex_wdata = '0;
    bus.mem_wreg = 1'b0; bus.mem_wd = '0; bus.mem_wdata = '0;
    bus.re1 = 1'b0;      bus.raddr1 = '0;
    bus.re2 = 1'b0;      bus.raddr2 = '0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    idle();
    set_rst(1'b0);

    // Reset state: outputs zero even with a live EX forward.
    bus.re1 = 1'b1; bus.raddr1 = 5'd1;
    bus.ex_wreg = 1'b1; bus.ex_wd = 5'd1; bus.ex_wdata = 32'h1111_1111;
    #1;
    expect_p1("por", 32'h0, 2'd0);
    tick();
    tick();
    set_rst(1'b1);
    idle();

    // Write r5, check bypass then array.
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'h1234_5678;
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    #1;
    expect_p1("r5_bypass", 32'h1234_5678, 2'd1);
    tick();
    bus.we = 1'b0;
    #1;
    expect_p1("r5_array", 32'h1234_5678, 2'd0);

    // Mid-run async reset clears r5 with no clock.
    #1;
    set_rst(1'b0);
    bus.ex_wreg = 1'b1; bus.ex_wd = 5'd5; bus.ex_wdata = 32'h5555_5555;
    #1;
    expect_p1("in_reset", 32'h0, 2'd0);
    #1;
    set_rst(1'b1);
    bus.ex_wreg = 1'b0;
    #1;
    expect_p1("r5_after_reset", 32'h0, 2'd0);
    tick();

    // Write presented on an edge while still in reset is dropped.
    set_rst(1'b0);
    bus.we = 1'b1; bus.waddr = 5'd6; bus.wdata = 32'h6666_6666;
    tick();
    set_rst(1'b1);
    bus.we = 1'b0;
    bus.raddr1 = 5'd6;
    #1;
    expect_p1("r6_no_write_in_reset", 32'h0, 2'd0);

    // Register 0 is immutable and never forwarded.
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFF_FFFF;
    tick();
    bus.we = 1'b0;
    bus.re1 = 1'b1; bus.raddr1 = 5'd0;
    bus.re2 = 1'b1; bus.raddr2 = 5'd0;
    #1;
    expect_p1("r0_read", 32'h0, 2'd0);
    expect_p2("r0_read", 32'h0, 2'd0);
    bus.ex_wreg = 1'b1; bus.ex_wd = 5'd0; bus.ex_wdata = 32'hAAAA_AAAA;
    #1;
    expect_p1("r0_ex", 32'h0, 2'd0);
    expect_p2("r0_ex", 32'h0, 2'd0);
    idle();

    // Write-then-read r7.
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'hDEAD_BEEF;
    bus.re1 = 1'b1; bus.raddr1 = 5'd7;
    #1;
    expect_p1("r7_bypass", 32'hDEAD_BEEF, 2'd1);
    tick();
    bus.we = 1'b0;
    #1;
    expect_p1("r7_array", 32'hDEAD_BEEF, 2'd0);

    // Three-way hazard on r3.
    bus.raddr1 = 5'd3;
    bus.ex_wreg = 1'b1;  bus.ex_wd = 5'd3;  bus.ex_wdata = 32'h3;
    bus.mem_wreg = 1'b1; bus.mem_wd = 5'd3; bus.mem_wdata = 32'h2;
    bus.we = 1'b1;       bus.waddr = 5'd3;  bus.wdata = 32'h1;
    #1;
    expect_p1("hz_ex", 32'h3, 2'd3);
    bus.ex_wreg = 1'b0;
    #1;
    expect_p1("hz_mem", 32'h2, 2'd2);
    bus.mem_wreg = 1'b0;
    #1;
    expect_p1("hz_wb", 32'h1, 2'd1);
    tick();
    idle();

    // Port independence: r4 from array, r9 from EX.
    bus.we = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h44;
    tick();
    bus.we = 1'b0;
    bus.re1 = 1'b1; bus.raddr1 = 5'd4;
    bus.re2 = 1'b1; bus.raddr2 = 5'd9;
    bus.ex_wreg = 1'b1; bus.ex_wd = 5'd9; bus.ex_wdata = 32'h0000_0099;
    #1;
    expect_p1("indep", 32'h44, 2'd0);
    expect_p2("indep", 32'h99, 2'd3);
    idle();

    // Disabled port 2 on a written r12 that is also an EX target.
    bus.we = 1'b1; bus.waddr = 5'd12; bus.wdata = 32'hC0DE_0012;
    tick();
    bus.we = 1'b0;
    bus.ex_wreg = 1'b1; bus.ex_wd = 5'd12; bus.ex_wdata = 32'h0BAD_F00D;
    bus.re1 = 1'b1; bus.raddr1 = 5'd12;
    bus.re2 = 1'b0; bus.raddr2 = 5'd12;
    #1;
    expect_p1("dis_p1", 32'h0BAD_F00D, 2'd3);
    expect_p2("dis_p2", 32'h0, 2'd0);
    idle();

    // Randomized traffic over a small address window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      bus.we        = 1'($urandom_range(0, 1));
      bus.waddr     = 5'($urandom_range(0, 7));
      bus.wdata     = $urandom;
      bus.ex_wreg   = 1'($urandom_range(0, 1));
      bus.ex_wd     = 5'($urandom_range(0, 7));
      bus.ex_wdata  = $urandom;
      bus.mem_wreg  = 1'($urandom_range(0, 1));
      bus.mem_wd    = 5'($urandom_range(0, 7));
      bus.mem_wdata = $urandom;
      bus.re1       = ($urandom_range(0, 7) != 0);
      bus.raddr1    = 5'($urandom_range(0, 7));
      bus.re2       = ($urandom_range(0, 7) != 0);
      bus.raddr2    = ($urandom_range(0, 3) == 0) ? bus.raddr1 : 5'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) set_rst(1'b0);
      #1;
      check_model("rnd");
      tick();
      if (!rst) set_rst(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
